alu_rr_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU (16 opcodes; 8-bit result {x,y}) between two requesters.
- Arbitration is round-robin.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Operands and opcode are registered on acceptance, and the ALU result is registered for return.
- Sits between two client FSMs and the shared ALU instance.

---
 rtl/alu_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU between two requesters.
// The optional ALU_ARB_STATS_EN macro adds saturating per-requester grant counters.
module alu_rr_arbiter #(
  parameter int DW    = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [3:0]    req0_opcode,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [3:0]    req1_opcode,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_x,
  output logic [DW-1:0] rsp0_y,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_x,
  output logic [DW-1:0] rsp1_y,
  output logic [3:0]    alu_opcode,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_x,
  input  logic [DW-1:0] alu_y
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; valid may drop before ready at no cost.

  if (DW != 4 || CNT_W < 1) begin : g_param_err
    $error("alu_rr_arbiter: DW must be 4 and CNT_W at least 1");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q;
  logic          rr_ptr_q;
  logic          owner_q;
  logic [3:0]    alu_opcode_q;
  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_b_q;
  logic          rsp0_valid_q;
  logic          rsp1_valid_q;
  logic [DW-1:0] rsp0_x_q;
  logic [DW-1:0] rsp0_y_q;
  logic [DW-1:0] rsp1_x_q;
  logic [DW-1:0] rsp1_y_q;

  logic win1;
  logic acc0;
  logic acc1;
  logic owner_rsp_ready;

  // Requester 1 wins when it is alone or when both contend and it holds priority.
  assign win1       = req1_valid && (!req0_valid || rr_ptr_q);
  assign req0_ready = (state_q == IDLE) && !rst && req0_valid && !win1;
  assign req1_ready = (state_q == IDLE) && !rst && win1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      owner_q      <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_x_q     <= '0;
      rsp0_y_q     <= '0;
      rsp1_x_q     <= '0;
      rsp1_y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc0 || acc1) begin
            owner_q      <= acc1;
            alu_opcode_q <= acc1 ? req1_opcode : req0_opcode;
            alu_a_q      <= acc1 ? req1_a : req0_a;
            alu_b_q      <= acc1 ? req1_b : req0_b;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (owner_q) begin
            rsp1_x_q     <= alu_x;
            rsp1_y_q     <= alu_y;
            rsp1_valid_q <= 1'b1;
          end else begin
            rsp0_x_q     <= alu_x;
            rsp0_y_q     <= alu_y;
            rsp0_valid_q <= 1'b1;
          end
          rr_ptr_q     <= ~owner_q;
          // ALU drive returns to zero as soon as the single execute cycle ends.
          alu_opcode_q <= '0;
          alu_a_q      <= '0;
          alu_b_q      <= '0;
          state_q      <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_x     = rsp0_x_q;
  assign rsp0_y     = rsp0_y_q;
  assign rsp1_x     = rsp1_x_q;
  assign rsp1_y     = rsp1_y_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0_q;
  logic [CNT_W-1:0] grant_cnt1_q;
  logic [CNT_W-1:0] grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (acc0 && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + 1'b1;
    if (acc1 && (grant_cnt1_q != '1)) grant_cnt1_d = grant_cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small behavioural ALU on the shared port.
// Build with +define+ALU_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_rr_arbiter;

  localparam int DW    = 4;
  localparam int CNT_W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_opcode = '0, req1_opcode = '0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [DW-1:0] rsp0_x, rsp0_y, rsp1_x, rsp1_y;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_a, alu_b, alu_x, alu_y;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_rr_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_x(rsp0_x), .rsp0_y(rsp0_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_x(rsp1_x), .rsp1_y(rsp1_y),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x), .alu_y(alu_y)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Stand-in ALU: 1010 add, 1100 mul, 0011 and, 1111 shift a right, else xor.
  logic [7:0] alu_res;
  always_comb begin
    alu_res = 8'h00;
    case (alu_opcode)
      4'b1010: alu_res = {4'h0, alu_a} + {4'h0, alu_b};
      4'b1100: alu_res = {4'h0, alu_a} * {4'h0, alu_b};
      4'b0011: alu_res = {4'h0, alu_a & alu_b};
      4'b1111: alu_res = {4'h0, alu_a >> 1};
      default: alu_res = {4'h0, alu_a ^ alu_b};
    endcase
  end
  assign alu_x = alu_res[7:4];
  assign alu_y = alu_res[3:0];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Issue one op as the sole requester with response ready high; ends back in IDLE.
  task automatic run_op(input bit who, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    if (who) begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    tick();
    tick();
    at_neg();
    n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_req0_ready: got %b want 0", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_req1_ready: got %b want 0", req1_ready); end
    n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    n_cmp++; if ({rsp0_x, rsp0_y, rsp1_x, rsp1_y} !== 16'h0000) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0000", {rsp0_x, rsp0_y, rsp1_x, rsp1_y}); end
    n_cmp++; if ({alu_opcode, alu_a, alu_b} !== 12'h000) begin n_err++; $display("FAIL rst_alu_drive: got %h want 000", {alu_opcode, alu_a, alu_b}); end
`ifdef ALU_ARB_STATS_EN
    n_cmp++; if ({grant_cnt0, grant_cnt1} !== '0) begin n_err++; $display("FAIL rst_grant_cnt: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); end
`endif
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_opcode = 4'b1010; req0_a = 4'h9; req0_b = 4'h8;
    rsp0_ready = 1'b1;
    at_neg();
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    at_neg();
    n_cmp++; if ({alu_opcode, alu_a, alu_b} !== 12'hA98) begin n_err++; $display("FAIL single_alu_drive: got %h want a98", {alu_opcode, alu_a, alu_b}); end
    n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_early: got %b want 0", rsp0_valid); end
    tick();
    at_neg();
    n_cmp++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp0_valid: got %b want 1", rsp0_valid); end
    n_cmp++; if ({rsp0_x, rsp0_y} !== 8'h11) begin n_err++; $display("FAIL single_rsp0_data: got %h want 11", {rsp0_x, rsp0_y}); end
    n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp1_valid: got %b want 0", rsp1_valid); end
    n_cmp++; if ({alu_opcode, alu_a, alu_b} !== 12'h000) begin n_err++; $display("FAIL single_alu_idle: got %h want 000", {alu_opcode, alu_a, alu_b}); end
    tick();
    at_neg();
    n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp0_drop: got %b want 0", rsp0_valid); end
  endtask

  task automatic test_contention();
    logic exp1;
    do_reset();
    req0_valid = 1'b1; req0_opcode = 4'b1100; req0_a = 4'h3; req0_b = 4'h5;
    req1_valid = 1'b1; req1_opcode = 4'b1111; req1_a = 4'hA; req1_b = 4'h0;
    for (int i = 0; i < 4; i++) begin
      exp1 = (i % 2 == 1);
      at_neg();
      n_cmp++; if ({req0_ready, req1_ready} !== {~exp1, exp1}) begin n_err++; $display("FAIL cont_grant%0d: got %b want %b", i, {req0_ready, req1_ready}, {~exp1, exp1}); end
      tick();
      at_neg();
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL cont_exec_ready%0d: got %b want 00", i, {req0_ready, req1_ready}); end
      tick();
      at_neg();
      if (exp1) begin
        n_cmp++; if ({rsp1_valid, rsp0_valid, rsp1_x, rsp1_y} !== 10'b10_0000_0101) begin n_err++; $display("FAIL cont_rsp1_%0d: got v1=%b v0=%b %h%h want v1=1 v0=0 05", i, rsp1_valid, rsp0_valid, rsp1_x, rsp1_y); end
      end else begin
        n_cmp++; if ({rsp0_valid, rsp1_valid, rsp0_x, rsp0_y} !== 10'b10_0000_1111) begin n_err++; $display("FAIL cont_rsp0_%0d: got v0=%b v1=%b %h%h want v0=1 v1=0 0f", i, rsp0_valid, rsp1_valid, rsp0_x, rsp0_y); end
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_valid = 1'b1; req1_opcode = 4'b0011; req1_a = 4'hC; req1_b = 4'hA;
    rsp1_ready = 1'b0;
    at_neg();
    n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_req1_ready: got %b want 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_opcode = 4'b1010; req0_a = 4'h1; req0_b = 4'h2;
    tick();
    for (int i = 0; i < 5; i++) begin
      at_neg();
      n_cmp++; if ({rsp1_valid, rsp1_x, rsp1_y, req0_ready} !== 10'b1_0000_1000_0) begin n_err++; $display("FAIL bp_hold%0d: got v=%b %h%h r0=%b want v=1 08 r0=0", i, rsp1_valid, rsp1_x, rsp1_y, req0_ready); end
      tick();
    end
    rsp1_ready = 1'b1;
    at_neg();
    n_cmp++; if ({rsp1_valid, req0_ready} !== 2'b10) begin n_err++; $display("FAIL bp_release: got v=%b r0=%b want v=1 r0=0", rsp1_valid, req0_ready); end
    tick();
    at_neg();
    n_cmp++; if ({rsp1_valid, req0_ready} !== 2'b01) begin n_err++; $display("FAIL bp_after: got v=%b r0=%b want v=0 r0=1", rsp1_valid, req0_ready); end
    tick();
    req0_valid = 1'b0;
    tick();
    at_neg();
    n_cmp++; if ({rsp0_valid, rsp0_x, rsp0_y} !== 9'b1_0000_0011) begin n_err++; $display("FAIL bp_req0_rsp: got v=%b %h%h want v=1 03", rsp0_valid, rsp0_x, rsp0_y); end
    tick();
  endtask

  task automatic test_sole();
    do_reset();
    run_op(1'b0, 4'b0001, 4'h6, 4'h3);
    req0_valid = 1'b1; req0_opcode = 4'b0001; req0_a = 4'h6; req0_b = 4'h5;
    at_neg();
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL sole_regrant: got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    tick();
    at_neg();
    n_cmp++; if ({rsp0_valid, rsp0_x, rsp0_y} !== 9'b1_0000_0011) begin n_err++; $display("FAIL sole_rsp0: got v=%b %h%h want v=1 03", rsp0_valid, rsp0_x, rsp0_y); end
    tick();
  endtask

  task automatic test_reset_mid();
    // Reset while the operation is executing.
    do_reset();
    req0_valid = 1'b1; req0_opcode = 4'b1010; req0_a = 4'h7; req0_b = 4'h7;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    n_cmp++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, alu_opcode} !== 8'h00) begin n_err++; $display("FAIL rexec_outputs: got %b want 00000000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready, alu_opcode}); end
    tick();
    at_neg();
    n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rexec_stale: got %b want 00", {rsp0_valid, rsp1_valid}); end
    tick();
    // Reset while a response is pending; req0 owned it, so only reset restores priority to 0.
    req0_valid = 1'b1;
    rsp0_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    at_neg();
    n_cmp++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL rresp_pending: got %b want 1", rsp0_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp0_ready = 1'b1;
    at_neg();
    n_cmp++; if ({rsp0_valid, rsp1_valid, alu_opcode} !== 6'h00) begin n_err++; $display("FAIL rresp_outputs: got %b want 000000", {rsp0_valid, rsp1_valid, alu_opcode}); end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rresp_rr_ptr: got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    run_op(1'b0, 4'b0001, 4'h1, 4'h1);
    run_op(1'b1, 4'b0001, 4'h1, 4'h1);
    run_op(1'b0, 4'b0001, 4'h1, 4'h1);
    run_op(1'b1, 4'b0001, 4'h1, 4'h1);
    run_op(1'b0, 4'b0001, 4'h1, 4'h1);
    at_neg();
    n_cmp++; if (grant_cnt0 !== 8'd3) begin n_err++; $display("FAIL stats_cnt0: got %0d want 3", grant_cnt0); end
    n_cmp++; if (grant_cnt1 !== 8'd2) begin n_err++; $display("FAIL stats_cnt1: got %0d want 2", grant_cnt1); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_sole();
    test_reset_mid();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
